// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full adder (two half adders + OR)
// walks a WIDTH-bit add LSB-first. Optional ovf_out port under SERIAL_ADD_OVF_EN.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s_out,
    output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf_out
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    // Only WIDTH-1 bits are kept: the bit shifted in on the final edge goes
    // straight into s_out, so a full-width register would never read its LSB.
    logic [WIDTH-2:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ha0_s, ha0_c, ha1_c, fa_s, fa_c;

    half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]),  .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.a(ha0_s),  .b(carry_q), .s(fa_s),  .c(ha1_c));
    assign fa_c = ha0_c | ha1_c;

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = c_in;
                    cnt_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (WIDTH-1)'({fa_s, sum_q} >> 1);
                carry_d = fa_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    s_d     = {fa_s, sum_q};
                    c_d     = fa_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q here is the carry into the MSB position
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s_out = s_q;
    assign c_out = c_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf_out = ovf_q;
`endif

endmodule
